// File: rtl/branch_pc_unit_.sv
// branch_pc_unit_ : architectural PC register and branch/jump resolution.
//
// Consumes the 0/1 comparison word from the ALU and turns the current
// instruction's branch operation into the next fetch address.
//
// Build option: define BRANCH_DELAY_SLOT_EN to give every taken branch or
// jump one delay-slot instruction at pc+4 before the target is fetched.
// Without it, taken resolutions load the target immediately. The port list
// is the same in both builds.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   adv        in   fetch advance; pc only moves when 1
//   br_op      in   00 seq, 01 branch-if-true, 10 branch-if-false, 11 jump
//   cmp_valid  in   cmp_result is valid for the current instruction
//   cmp_result in   comparison word, nonzero = true
//   br_imm     in   signed word offset for branches
//   j_target   in   word index for jumps
//   pc         out  current PC (registered)
//   redirect   out  one-cycle pulse after pc is loaded with a non-sequential target
//   stall      out  combinational: branch waiting on a valid comparison
//   taken_cnt  out  saturating count of taken branches and jumps

module branch_pc_unit_ #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             adv,
    input  logic [1:0]       br_op,
    input  logic             cmp_valid,
    input  logic [31:0]      cmp_result,
    input  logic [15:0]      br_imm,
    input  logic [25:0]      j_target,
    output logic [31:0]      pc,
    output logic             redirect,
    output logic             stall,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [1:0] OpSeq     = 2'b00;
    localparam logic [1:0] OpBrTrue  = 2'b01;
    localparam logic [1:0] OpBrFalse = 2'b10;
    localparam logic [1:0] OpJump    = 2'b11;

    logic [31:0]      pc_q, pc_d;
    logic             redirect_q, redirect_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

    logic [31:0] seq;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic [31:0] target;
    logic        is_branch;
    logic        cond;
    logic        in_slot;
    logic        resolve;
    logic        taken;

    // ---------------------------------------------------------------
    // Address arithmetic (all modulo 2^32)
    // ---------------------------------------------------------------
    assign seq    = pc_q + 32'd4;
    assign br_tgt = seq + {{14{br_imm[15]}}, br_imm, 2'b00};
    assign j_tgt  = {seq[31:28], j_target, 2'b00};
    assign target = (br_op == OpJump) ? j_tgt : br_tgt;

    assign is_branch = (br_op == OpBrTrue) || (br_op == OpBrFalse);

    always_comb begin
        cond = 1'b0;
        unique case (br_op)
            OpSeq:     cond = 1'b0;
            OpBrTrue:  cond = |cmp_result;
            OpBrFalse: cond = ~|cmp_result;
            OpJump:    cond = 1'b1;
            default:   cond = 1'b0;
        endcase
    end

    // ---------------------------------------------------------------
    // Delay-slot FSM (RUN/SLOT) and pending-target latch
    // ---------------------------------------------------------------
`ifdef BRANCH_DELAY_SLOT_EN
    typedef enum logic {StRun, StSlot} state_e;

    state_e      state_q, state_d;
    logic [31:0] tgt_q, tgt_d;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (taken) state_d = StSlot;
            StSlot:  if (adv) state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    assign in_slot = (state_q == StSlot);

    // Output / datapath logic: the slot instruction's own inputs are ignored
    always_comb begin
        pc_d       = pc_q;
        redirect_d = 1'b0;
        tgt_d      = tgt_q;
        if (in_slot) begin
            if (adv) begin
                pc_d       = tgt_q;
                redirect_d = 1'b1;
            end
        end else if (resolve) begin
            pc_d = seq;
            if (taken) begin
                tgt_d = target;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tgt_q <= 32'h0000_0000;
        end else begin
            tgt_q <= tgt_d;
        end
    end
`else
    assign in_slot = 1'b0;

    always_comb begin
        pc_d       = pc_q;
        redirect_d = 1'b0;
        if (resolve) begin
            if (taken) begin
                pc_d       = target;
                redirect_d = 1'b1;
            end else begin
                pc_d = seq;
            end
        end
    end
`endif

    // A branch without a valid comparison holds fetch; never in the slot
    assign stall   = adv & is_branch & ~cmp_valid & ~in_slot;
    assign resolve = adv & ~stall & ~in_slot;
    assign taken   = resolve & cond;

    always_comb begin
        taken_cnt_d = taken_cnt_q;
        if (taken && (taken_cnt_q != {CNT_W{1'b1}})) begin
            taken_cnt_d = taken_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q        <= RESET_PC;
            redirect_q  <= 1'b0;
            taken_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            redirect_q  <= redirect_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign pc        = pc_q;
    assign redirect  = redirect_q;
    assign taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_branch_pc_unit_.sv
// Self-checking bench for branch_pc_unit_. Two instances share all inputs:
// dut0 (RESET_PC 0040_0000, 16-bit counter) and dut1 (RESET_PC 1000_0000,
// 2-bit counter, used for jump-region and saturation checks).
`timescale 1ns/1ps

module tb_branch_pc_unit_;

`ifdef BRANCH_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        adv;
    logic [1:0]  br_op;
    logic        cmp_valid;
    logic [31:0] cmp_result;
    logic [15:0] br_imm;
    logic [25:0] j_target;

    logic [31:0] pc0, pc1;
    logic        redirect0, redirect1;
    logic        stall0, stall1;
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    int n_checks;
    int n_errors;

    branch_pc_unit_ #(.RESET_PC(32'h0040_0000), .CNT_W(16)) dut0 (
        .clk(clk), .reset_n(reset_n), .adv(adv), .br_op(br_op), .cmp_valid(cmp_valid),
        .cmp_result(cmp_result), .br_imm(br_imm), .j_target(j_target),
        .pc(pc0), .redirect(redirect0), .stall(stall0), .taken_cnt(cnt0)
    );

    branch_pc_unit_ #(.RESET_PC(32'h1000_0000), .CNT_W(2)) dut1 (
        .clk(clk), .reset_n(reset_n), .adv(adv), .br_op(br_op), .cmp_valid(cmp_valid),
        .cmp_result(cmp_result), .br_imm(br_imm), .j_target(j_target),
        .pc(pc1), .redirect(redirect1), .stall(stall1), .taken_cnt(cnt1)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0]  m_pc[2];
    logic [31:0]  m_tgt[2];
    bit           m_slot[2];
    bit           m_redir[2];
    int unsigned  m_cnt[2];
    int unsigned  cnt_max[2] = '{65535, 3};
    logic [31:0]  rst_pc[2]  = '{32'h0040_0000, 32'h1000_0000};

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pc[d]    = rst_pc[d];
            m_tgt[d]   = 32'h0;
            m_slot[d]  = 1'b0;
            m_redir[d] = 1'b0;
            m_cnt[d]   = 0;
        end
    endtask

    function automatic bit m_stall(int d);
        return adv && (br_op == 2'd1 || br_op == 2'd2) && !cmp_valid && !m_slot[d];
    endfunction

    task automatic model_step();
        logic [31:0] seq, tgt;
        bit          tk;
        int          off;
        for (int d = 0; d < 2; d++) begin
            seq = m_pc[d] + 32'd4;
            m_redir[d] = 1'b0;
            if (adv) begin
                if (m_slot[d]) begin
                    m_pc[d]    = m_tgt[d];
                    m_redir[d] = 1'b1;
                    m_slot[d]  = 1'b0;
                end else if (!m_stall(d)) begin
                    tk = (br_op == 2'd3) || (br_op == 2'd1 && cmp_result != 0) ||
                         (br_op == 2'd2 && cmp_result == 0);
                    off = int'($signed(br_imm)) * 4;
                    tgt = (br_op == 2'd3) ? {seq[31:28], j_target, 2'b00} : seq + 32'(off);
                    if (tk) begin
                        if (m_cnt[d] < cnt_max[d]) m_cnt[d]++;
                        if (DS) begin
                            m_pc[d]   = seq;
                            m_tgt[d]  = tgt;
                            m_slot[d] = 1'b1;
                        end else begin
                            m_pc[d]    = tgt;
                            m_redir[d] = 1'b1;
                        end
                    end else begin
                        m_pc[d] = seq;
                    end
                end
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic a, input logic [1:0] op, input logic cv,
                         input logic [31:0] cr, input logic [15:0] imm, input logic [25:0] jt);
        adv = a; br_op = op; cmp_valid = cv; cmp_result = cr; br_imm = imm; j_target = jt;
        #1;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #2;
        reset_n = 1'b1;
    endtask

    // Jump to {region, jt, 00}, including the slot cycle in the delay-slot build
    task automatic go_jump(input logic [25:0] jt);
        drive(1'b1, 2'd3, 1'b1, 32'h0, 16'h0, jt);
        tick();
        if (DS) begin
            drive(1'b1, 2'd0, 1'b1, 32'h0, 16'h0, 26'h0);
            tick();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_checks++;
        if (pc0 !== 32'h0040_0000 || cnt0 !== 16'h0 || redirect0 !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state pc=%h cnt=%0d redir=%b want pc=00400000 cnt=0 redir=0",
                     pc0, cnt0, redirect0);
        end
        go_jump(26'h0000123);
        drive(1'b1, 2'd0, 1'b1, 32'h0, 16'h0, 26'h0);
        tick();
        reset_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (pc0 !== 32'h0040_0000 || cnt0 !== 16'h0 || pc1 !== 32'h1000_0000) begin
            n_errors++;
            $display("FAIL async_reset pc0=%h cnt0=%0d pc1=%h want 00400000 0 10000000",
                     pc0, cnt0, pc1);
        end
        #1;
        reset_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 2'd0, 1'b0, 32'h0, 16'h0, 26'h0);
            tick();
            n_checks++;
            if (pc0 !== 32'h0040_0000 + 32'(4 * i)) begin
                n_errors++;
                $display("FAIL reset_seq%0d pc=%h want %h", i, pc0, 32'h0040_0000 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_jump();
        do_reset();
        drive(1'b1, 2'd3, 1'b0, 32'h0, 16'h0, 26'h0000040);
        tick();
`ifdef BRANCH_DELAY_SLOT_EN
        n_checks++;
        if (pc0 !== 32'h0040_0004 || redirect0 !== 1'b0) begin
            n_errors++;
            $display("FAIL jump_slot pc=%h redir=%b want 00400004 0", pc0, redirect0);
        end
        drive(1'b1, 2'd0, 1'b0, 32'h0, 16'h0, 26'h0);
        tick();
`endif
        n_checks++;
        if (pc0 !== 32'h0000_0100 || pc1 !== 32'h1000_0100 || redirect0 !== 1'b1) begin
            n_errors++;
            $display("FAIL jump pc0=%h pc1=%h redir=%b want 00000100 10000100 1",
                     pc0, pc1, redirect0);
        end
        n_checks++;
        if (cnt0 !== 16'd1 || cnt1 !== 2'd1) begin
            n_errors++;
            $display("FAIL jump_cnt cnt0=%0d cnt1=%0d want 1 1", cnt0, cnt1);
        end
    endtask

    task automatic test_branch();
        drive(1'b1, 2'd1, 1'b1, 32'h1, 16'hFFFE, 26'h0);
        tick();
`ifdef BRANCH_DELAY_SLOT_EN
        n_checks++;
        if (pc0 !== 32'h0000_0104 || redirect0 !== 1'b0) begin
            n_errors++;
            $display("FAIL branch_slot pc=%h redir=%b want 00000104 0", pc0, redirect0);
        end
        drive(1'b1, 2'd0, 1'b0, 32'h0, 16'h0, 26'h0);
        tick();
`endif
        n_checks++;
        if (pc0 !== 32'h0000_00FC || redirect0 !== 1'b1 || cnt0 !== 16'd2) begin
            n_errors++;
            $display("FAIL branch_taken pc=%h redir=%b cnt=%0d want 000000fc 1 2",
                     pc0, redirect0, cnt0);
        end
        drive(1'b0, 2'd3, 1'b1, 32'h1, 16'h0, 26'h0);
        tick();
        n_checks++;
        if (pc0 !== 32'h0000_00FC || redirect0 !== 1'b0 || cnt0 !== 16'd2) begin
            n_errors++;
            $display("FAIL hold_adv0 pc=%h redir=%b cnt=%0d want 000000fc 0 2",
                     pc0, redirect0, cnt0);
        end
        drive(1'b1, 2'd2, 1'b1, 32'h1, 16'hFFFE, 26'h0);
        tick();
        n_checks++;
        if (pc0 !== 32'h0000_0100 || redirect0 !== 1'b0 || cnt0 !== 16'd2) begin
            n_errors++;
            $display("FAIL branch_not_taken pc=%h redir=%b cnt=%0d want 00000100 0 2",
                     pc0, redirect0, cnt0);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'd1, 1'b0, 32'h5, 16'h0040, 26'h0);
            n_checks++;
            if (stall0 !== 1'b1) begin
                n_errors++;
                $display("FAIL stall_on%0d stall=%b want 1", i, stall0);
            end
            tick();
            n_checks++;
            if (pc0 !== 32'h0000_0100 || cnt0 !== 16'd2) begin
                n_errors++;
                $display("FAIL stall_hold%0d pc=%h cnt=%0d want 00000100 2", i, pc0, cnt0);
            end
        end
        drive(1'b0, 2'd2, 1'b0, 32'h0, 16'h0, 26'h0);
        n_checks++;
        if (stall0 !== 1'b0) begin
            n_errors++;
            $display("FAIL stall_noadv stall=%b want 0", stall0);
        end
        drive(1'b1, 2'd1, 1'b1, 32'h0, 16'h0040, 26'h0);
        n_checks++;
        if (stall0 !== 1'b0) begin
            n_errors++;
            $display("FAIL stall_off stall=%b want 0", stall0);
        end
        tick();
        n_checks++;
        if (pc0 !== 32'h0000_0104) begin
            n_errors++;
            $display("FAIL stall_release pc=%h want 00000104", pc0);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        go_jump(26'h0);
        drive(1'b1, 2'd1, 1'b1, 32'h8000_0000, 16'hFFFE, 26'h0);
        tick();
`ifdef BRANCH_DELAY_SLOT_EN
        drive(1'b1, 2'd0, 1'b0, 32'h0, 16'h0, 26'h0);
        tick();
`endif
        n_checks++;
        if (pc0 !== 32'hFFFF_FFFC) begin
            n_errors++;
            $display("FAIL wrap_setup pc=%h want fffffffc", pc0);
        end
        drive(1'b1, 2'd0, 1'b0, 32'h0, 16'h0, 26'h0);
        tick();
        n_checks++;
        if (pc0 !== 32'h0000_0000 || redirect0 !== 1'b0) begin
            n_errors++;
            $display("FAIL wrap pc=%h redir=%b want 00000000 0", pc0, redirect0);
        end
    endtask

`ifdef BRANCH_DELAY_SLOT_EN
    task automatic test_delay_slot();
        int unsigned c0;
        do_reset();
        go_jump(26'h0000080);
        c0 = m_cnt[0];
        drive(1'b1, 2'd1, 1'b1, 32'h1, 16'd8, 26'h0);
        tick();
        n_checks++;
        if (pc0 !== 32'h0000_0204 || redirect0 !== 1'b0 || cnt0 !== 16'(c0 + 1)) begin
            n_errors++;
            $display("FAIL ds_slot pc=%h redir=%b cnt=%0d want 00000204 0 %0d",
                     pc0, redirect0, cnt0, c0 + 1);
        end
        drive(1'b1, 2'd3, 1'b0, $urandom, 16'($urandom), 26'($urandom));
        n_checks++;
        if (stall0 !== 1'b0) begin
            n_errors++;
            $display("FAIL ds_stall stall=%b want 0", stall0);
        end
        tick();
        n_checks++;
        if (pc0 !== 32'h0000_0224 || redirect0 !== 1'b1 || cnt0 !== 16'(c0 + 1)) begin
            n_errors++;
            $display("FAIL ds_redirect pc=%h redir=%b cnt=%0d want 00000224 1 %0d",
                     pc0, redirect0, cnt0, c0 + 1);
        end
        drive(1'b1, 2'd1, 1'b1, 32'h1, 16'd8, 26'h0);
        tick();
        reset_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (pc0 !== 32'h0040_0000 || redirect0 !== 1'b0) begin
            n_errors++;
            $display("FAIL ds_reset pc=%h redir=%b want 00400000 0", pc0, redirect0);
        end
        reset_n = 1'b1;
        drive(1'b1, 2'd0, 1'b0, 32'h0, 16'h0, 26'h0);
        tick();
        n_checks++;
        if (pc0 !== 32'h0040_0004 || redirect0 !== 1'b0) begin
            n_errors++;
            $display("FAIL ds_after_reset pc=%h redir=%b want 00400004 0", pc0, redirect0);
        end
    endtask
`endif

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 5; i++) go_jump(26'($urandom));
        n_checks++;
        if (cnt1 !== 2'd3 || cnt0 !== 16'd5) begin
            n_errors++;
            $display("FAIL saturation cnt1=%0d cnt0=%0d want 3 5", cnt1, cnt0);
        end
    endtask

    task automatic test_random();
        logic [31:0] cr;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) == 0) do_reset();
            cr = ($urandom_range(1) == 0) ? 32'h0 : (($urandom_range(1) == 0) ? 32'h1 : $urandom);
            drive($urandom_range(3) != 0, 2'($urandom), $urandom_range(3) != 0, cr,
                  ($urandom_range(1) == 0) ? 16'($urandom) : 16'($urandom_range(16)),
                  26'($urandom));
            n_checks++;
            if (stall0 !== m_stall(0) || stall1 !== m_stall(1)) begin
                n_errors++;
                $display("FAIL rnd_stall%0d got %b/%b want %b/%b", i, stall0, stall1,
                         m_stall(0), m_stall(1));
            end
            tick();
            n_checks++;
            if (pc0 !== m_pc[0] || pc1 !== m_pc[1]) begin
                n_errors++;
                $display("FAIL rnd_pc%0d got %h/%h want %h/%h", i, pc0, pc1, m_pc[0], m_pc[1]);
            end
            n_checks++;
            if (redirect0 !== m_redir[0] || redirect1 !== m_redir[1]) begin
                n_errors++;
                $display("FAIL rnd_redirect%0d got %b/%b want %b/%b", i, redirect0, redirect1,
                         m_redir[0], m_redir[1]);
            end
            n_checks++;
            if (cnt0 !== 16'(m_cnt[0]) || cnt1 !== 2'(m_cnt[1])) begin
                n_errors++;
                $display("FAIL rnd_cnt%0d got %0d/%0d want %0d/%0d", i, cnt0, cnt1,
                         m_cnt[0], m_cnt[1]);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clk = 1'b0;
        reset_n = 1'b0;
        adv = 1'b0; br_op = 2'd0; cmp_valid = 1'b0; cmp_result = 32'h0;
        br_imm = 16'h0; j_target = 26'h0;
        model_reset();
        #13;
        reset_n = 1'b1;
        test_reset();
        test_jump();
        test_branch();
        test_stall();
        test_wrap();
`ifdef BRANCH_DELAY_SLOT_EN
        test_delay_slot();
`endif
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/branch_pc_unit_.md
# branch_pc_unit_

Sequential consumer of the ALU comparison words (the 32-bit 0/1 results produced by the `slt_`/`bne_`-style comparison components). Owns the architectural PC register and resolves conditional branches and jumps into the next fetch address. Sits between the ALU comparison path and instruction fetch. Optionally implements the MIPS branch delay slot through a small state machine.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `CNT_W`, default 16: width of the taken-branch counter.

- `clk` in 1: single clock; all state updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `adv` in 1: fetch advance; the PC may update only in a cycle with `adv`=1.
- `br_op` in 2: operation of the current instruction.
  - 00: sequential.
  - 01: branch if true.
  - 10: branch if false.
  - 11: jump.
- `cmp_valid` in 1: `cmp_result` is valid for the current instruction.
- `cmp_result` in 32: comparison word. Any nonzero value = true.
- `br_imm` in 16: signed word offset.
- `j_target` in 26: jump word index.
- `pc` out 32: current PC (registered).
- `redirect` out 1: one-cycle pulse in the cycle after the PC is loaded with a non-sequential target.
- `stall` out 1: combinational. 1 when `adv`=1, `br_op` is 01/10, `cmp_valid`=0 and the unit is not in the delay slot.
- `taken_cnt` out CNT_W: count of taken branches and jumps. Saturates at all-ones.

## Operation
- Arithmetic:
  - `seq` = `pc`+4, modulo 2^32; wraps from FFFF_FFFC to 0000_0000.
  - Branch target = `seq` + (sign-extended `br_imm` << 2), modulo 2^32.
  - Jump target = {`seq`[31:28], `j_target`, 2'b00}.
- Taken:
  - op 01: `cmp_result`≠0.
  - op 10: `cmp_result`==0.
  - op 11: always taken.
  - op 00: never taken.
- Resolution occurs in a cycle with `adv`=1 and no stall. With `adv`=0, `pc`, the FSM state and `taken_cnt` all hold.
- A stalled cycle holds `pc`, does not count and does not change state.
- `taken_cnt` increments by 1 per taken resolution. It holds at 2^CNT_W−1.
- FSM states:
  - RUN: normal resolution.
  - SLOT: a taken target is pending; only entered when BRANCH_DELAY_SLOT_EN is defined.
- RUN, taken:
  - Without the macro: `pc` ← target, `redirect` pulses.
  - With the macro: `pc` ← `seq`, target is latched, state → SLOT.
- RUN, not taken: `pc` ← `seq`.
- SLOT, on `adv`: `pc` ← latched target, `redirect` pulses, state → RUN.
  - `br_op`, `cmp_*` and the imm/target inputs are ignored in SLOT. A branch in the delay slot is not evaluated and not counted.
  - `stall` is 0 in SLOT.
- Reset (asynchronous, at any time including mid-SLOT):
  - `pc`=RESET_PC, state=RUN, latched target=0, `redirect`=0, `taken_cnt`=0.
  - `stall` follows the inputs.

## Timing
- Latency: `pc` reflects a resolution on the rising edge that samples `adv`=1. `redirect` is high for exactly the following cycle.
- Delay-slot build: the target appears in `pc` on the second advancing edge after the branch. Cycles with `adv`=0 in between extend the gap.
- `stall` is combinational from `adv`, `br_op`, `cmp_valid` and the state. No other input-to-output combinational path exists.
- Release of reset is handled asynchronously; the first update occurs on the first `clk` edge with `reset_n`=1 and `adv`=1.

## Configuration
- `BRANCH_DELAY_SLOT_EN`:
  - Defined: the SLOT state and target latch exist; every taken branch or jump executes one delay-slot instruction at `seq` before redirecting.
  - Undefined: the FSM is RUN only and taken resolutions load the target immediately; the latch and SLOT logic are not synthesized.
  - Port list is identical in both builds.

## Test plan
- Reset: drive `reset_n`=0 mid-run with RESET_PC=32'h0040_0000 → `pc`=0040_0000 and `taken_cnt`=0 immediately, without a clock edge. Three advancing cycles with op 00 → `pc` steps 0040_0004, 0040_0008, 0040_000C.
- Branch taken, no macro: `pc`=0000_0100, op 01, `cmp_result`=1, `br_imm`=16'hFFFE → `pc`=0000_00FC, then `redirect`=1 for one cycle, `taken_cnt`=1. Same stimulus with op 10 → `pc`=0000_0104, no redirect.
- Stall: op 01, `cmp_valid`=0, `adv`=1 for 3 cycles → `stall`=1 and `pc` held. Raise `cmp_valid` with `cmp_result`=0 → `pc` advances by 4, `stall`=0.
- Jump and wrap:
  - `pc`=FFFF_FFFC, op 00 → `pc`=0000_0000.
  - `pc`=1000_0000, op 11, `j_target`=26'h0000040 → `pc`=1000_0100.
- Delay slot (macro defined): `pc`=0000_0200, op 01, `cmp_result`=32'h1, `br_imm`=8 → next `pc`=0000_0204. Then, with op 11 present on the inputs, → `pc`=0000_0224, `redirect` pulses and `taken_cnt`=1 (the slot jump is ignored). Repeat with `reset_n` asserted while in SLOT → state RUN and `pc`=RESET_PC.
- Counter saturation: CNT_W=2, five taken jumps → `taken_cnt`=3.
